// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, valid/ready handshake.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd,
    output logic            o_busy
);

    localparam int unsigned     CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [2:0]          funct3_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CW-1:0]       cnt_q;
    logic                neg_q;
    logic                rneg_q;
    logic                bypass_q;
    logic [XLEN-1:0]     result_q;

    logic                is_div;
    logic                rs1_signed;
    logic                rs2_signed;
    logic                rs1_neg;
    logic                rs2_neg;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     rs1_mag;
    logic [XLEN-1:0]     rs2_mag;

    always_comb begin
        is_div     = i_funct3[2];
        rs1_signed = is_div ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
        rs2_signed = is_div ? ~i_funct3[0] : ~i_funct3[1];
        rs1_neg    = rs1_signed & i_rs1[XLEN-1];
        rs2_neg    = rs2_signed & i_rs2[XLEN-1];
        rs1_mag    = rs1_neg ? -i_rs1 : i_rs1;
        rs2_mag    = rs2_neg ? -i_rs2 : i_rs2;
        div_zero   = is_div && (i_rs2 == '0);
        div_ovf    = is_div && ~i_funct3[0] && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
    end

    // acc_q holds {hi, lo}: product accumulator / multiplier for MUL*,
    // partial remainder / dividend-shifting-into-quotient for DIV*/REM*.
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   step_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!funct3_q[2]) begin
            step_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     result_d;

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        // Special-case divides are preloaded with their final raw values.
        if (!bypass_q) begin
            if (neg_q) begin
                quo = -acc_q[XLEN-1:0];
            end
            if (rneg_q) begin
                rem = -acc_q[2*XLEN-1:XLEN];
            end
        end
        case (funct3_q)
            3'b000:                 result_d = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quo;
            default:                result_d = rem;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            rd_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bypass_q <= 1'b0;
            result_q <= '0;
        end else if (i_flush) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        funct3_q <= i_funct3;
                        rd_q     <= i_rd;
                        neg_q    <= rs1_neg ^ rs2_neg;
                        rneg_q   <= rs1_neg;
                        bypass_q <= div_zero | div_ovf;
                        opnd_q   <= is_div ? rs2_mag : rs1_mag;
                        // Bypassed ops start at the terminal count so CALC
                        // only spends its single result-forming cycle.
                        if (div_zero) begin
                            acc_q <= {i_rs1, {XLEN{1'b1}}};
                            cnt_q <= LAST;
                        end else if (div_ovf) begin
                            acc_q <= {{XLEN{1'b0}}, i_rs1};
                            cnt_q <= LAST;
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, (is_div ? rs1_mag : rs2_mag)};
                            cnt_q <= '0;
                        end
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == LAST) begin
                        result_q <= result_d;
                        state_q  <= DONE;
                    end else begin
                        acc_q <= step_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        result_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q != IDLE);
    assign o_result = (state_q == DONE) ? result_q : '0;
    assign o_rd     = (state_q == DONE) ? rd_q : '0;

endmodule
